// File: rtl/fir_xifu_ex_simd.sv
// fir_xifu_ex_simd: FIR XIFU execute stage (load/store handshake, SIMD dot product, WB result register).
module fir_xifu_ex_simd #(
    parameter int XLEN       = 32,
    parameter int ELEM_W     = 16,
    parameter int ID_W       = 4,
    parameter int MUL_STAGES = 1,
    parameter int CIRC_EN    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 id_valid_i,
    input  logic [1:0]           id_instr_i,
    input  logic [ID_W-1:0]      id_id_i,
    input  logic [4:0]           id_rd_i,
    input  logic [XLEN-1:0]      id_base_i,
    input  logic [11:0]          id_offset_i,
    input  logic [XLEN-1:0]      op_a_i,
    input  logic [XLEN-1:0]      op_b_i,
    input  logic [XLEN-1:0]      op_c_i,
    input  logic [XLEN-1:0]      buf_start_i,
    input  logic [XLEN-1:0]      buf_end_i,
    input  logic [2**ID_W-1:0]   issue_i,
    input  logic [2**ID_W-1:0]   commit_i,
    input  logic [2**ID_W-1:0]   kill_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [XLEN-1:0]      mem_addr_o,
    output logic                 mem_we_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    output logic [ID_W-1:0]      mem_id_o,
    output logic                 ready_o,
    output logic                 wb_valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      wb_result_o,
    output logic [4:0]           wb_rd_o,
    output logic [ID_W-1:0]      wb_id_o,
    output logic [1:0]           wb_instr_o
);
    localparam int LANES = XLEN / ELEM_W;
    localparam logic [1:0] I_NONE = 2'd0;
    localparam logic [1:0] I_SW   = 2'd2;
    localparam logic [1:0] I_DOTP = 2'd3;

    typedef enum logic [1:0] {IDLE, MEM, MUL} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q;
    logic [1:0]              instr_q;
    logic [ID_W-1:0]         id_q;
    logic [4:0]              rd_q;
    logic [XLEN-1:0]         addr_q, nxt_q, wdata_q, sum_q;
    logic [XLEN-1:0]         addr_d, inc_d, nxt_d, sum_d;
    logic signed [2*ELEM_W-1:0] lane_a, lane_b;
    logic                    accept, in_mem, kill_hit, mem_done, mul_done, imm_done, wb_write;

    assign ready_o  = (state_q == IDLE) & (~wb_valid_o | ready_i);
    assign accept   = id_valid_i & ready_o & (id_instr_i != I_NONE);
    assign in_mem   = state_q == MEM;
    assign kill_hit = kill_i[id_q];

    assign addr_d = id_base_i + {{(XLEN-12){id_offset_i[11]}}, id_offset_i};
    assign inc_d  = addr_d + XLEN'(4);
    assign nxt_d  = (CIRC_EN != 0 && inc_d >= buf_end_i) ? buf_start_i : inc_d;

    // Lanes are sign-extended to the full product width before multiplying.
    always_comb begin
        sum_d  = op_c_i;
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = (2*ELEM_W)'($signed(op_a_i[i*ELEM_W +: ELEM_W]));
            lane_b = (2*ELEM_W)'($signed(op_b_i[i*ELEM_W +: ELEM_W]));
            sum_d  = sum_d + XLEN'(lane_a * lane_b);
        end
    end

    assign mem_valid_o = in_mem & issue_i[id_q] & commit_i[id_q] & ~kill_hit;
    assign mem_addr_o  = in_mem ? addr_q : '0;
    assign mem_we_o    = in_mem & (instr_q == I_SW);
    assign mem_wdata_o = in_mem ? wdata_q : '0;
    assign mem_id_o    = in_mem ? id_q : '0;

    assign mem_done = mem_valid_o & mem_ready_i;
    assign mul_done = (state_q == MUL) & ~kill_hit & (cnt_q == 2'd1);
    assign imm_done = accept & (id_instr_i == I_DOTP) & (MUL_STAGES == 0);
    assign wb_write = mem_done | mul_done | imm_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (id_instr_i != I_DOTP) ? MEM : (MUL_STAGES == 0 ? IDLE : MUL);
            MEM:     if (kill_hit || mem_done) state_d = IDLE;
            MUL:     if (kill_hit || cnt_q == 2'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            instr_q     <= '0;
            id_q        <= '0;
            rd_q        <= '0;
            addr_q      <= '0;
            nxt_q       <= '0;
            wdata_q     <= '0;
            sum_q       <= '0;
            wb_valid_o  <= 1'b0;
            wb_result_o <= '0;
            wb_rd_o     <= '0;
            wb_id_o     <= '0;
            wb_instr_o  <= '0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_valid_o  <= 1'b0;
            wb_result_o <= '0;
            wb_rd_o     <= '0;
            wb_id_o     <= '0;
            wb_instr_o  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= accept ? 2'(MUL_STAGES) : (state_q == MUL ? cnt_q - 2'd1 : 2'd0);
            wb_valid_o <= wb_write | (wb_valid_o & ~ready_i);
            if (accept) begin
                instr_q <= id_instr_i;
                id_q    <= id_id_i;
                rd_q    <= id_rd_i;
                addr_q  <= addr_d;
                nxt_q   <= nxt_d;
                wdata_q <= op_b_i;
                sum_q   <= sum_d;
            end
            if (wb_write) begin
                wb_result_o <= imm_done ? sum_d : (mul_done ? sum_q : nxt_q);
                wb_rd_o     <= imm_done ? id_rd_i : rd_q;
                wb_id_o     <= imm_done ? id_id_i : id_q;
                wb_instr_o  <= imm_done ? I_DOTP : instr_q;
            end
        end
    end
endmodule

// File: tb/tb_fir_xifu_ex_simd.sv
// tb_fir_xifu_ex_simd: two instances (16-bit lanes/no mul pipe, 8-bit lanes/2 mul stages) checked against a lane-arithmetic model.
module tb_fir_xifu_ex_simd;
    logic clk_i = 1'b0;
    logic rst_i, clear_i, id_valid_i, mem_ready_i, ready_i;
    logic [1:0]  id_instr_i;
    logic [3:0]  id_id_i;
    logic [4:0]  id_rd_i;
    logic [31:0] id_base_i, op_a_i, op_b_i, op_c_i, buf_start_i, buf_end_i;
    logic [11:0] id_offset_i;
    logic [15:0] issue_i, commit_i, kill_i;
    logic [1:0]  mv, mwe, rdy, wbv;
    logic [1:0][31:0] ma, mwd, wbr;
    logic [1:0][3:0]  mid, wbid;
    logic [1:0][4:0]  wbrd;
    logic [1:0][1:0]  wbi;
    int total = 0, bad = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fir_xifu_ex_simd #(.XLEN(32), .ELEM_W(g == 0 ? 16 : 8), .ID_W(4),
                           .MUL_STAGES(g == 0 ? 0 : 2), .CIRC_EN(1)) u_dut (
            .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
            .id_valid_i(id_valid_i), .id_instr_i(id_instr_i), .id_id_i(id_id_i), .id_rd_i(id_rd_i),
            .id_base_i(id_base_i), .id_offset_i(id_offset_i),
            .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
            .buf_start_i(buf_start_i), .buf_end_i(buf_end_i),
            .issue_i(issue_i), .commit_i(commit_i), .kill_i(kill_i),
            .mem_valid_o(mv[g]), .mem_ready_i(mem_ready_i), .mem_addr_o(ma[g]), .mem_we_o(mwe[g]),
            .mem_wdata_o(mwd[g]), .mem_id_o(mid[g]), .ready_o(rdy[g]),
            .wb_valid_o(wbv[g]), .ready_i(ready_i), .wb_result_o(wbr[g]),
            .wb_rd_o(wbrd[g]), .wb_id_o(wbid[g]), .wb_instr_o(wbi[g])
        );
    end

    function automatic logic [31:0] m_dotp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int ew);
        logic [31:0] s = c;
        for (int i = 0; i < 32 / ew; i++) begin
            int x = int'((a >> (i * ew)) & ((32'd1 << ew) - 1));
            int y = int'((b >> (i * ew)) & ((32'd1 << ew) - 1));
            if (x >= (1 << (ew - 1))) x -= (1 << ew);
            if (y >= (1 << (ew - 1))) y -= (1 << ew);
            s = s + 32'(x * y);
        end
        return s;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] base, input logic [11:0] off);
        int o = int'(off);
        if (o >= 2048) o -= 4096;
        return base + 32'(o);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] addr);
        logic [31:0] n = addr + 32'd4;
        return (n >= buf_end_i) ? buf_start_i : n;
    endfunction

    task automatic nedge();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        clear_i = 0; id_valid_i = 0; id_instr_i = 0; id_id_i = 0; id_rd_i = 0;
        id_base_i = 0; id_offset_i = 0; op_a_i = 0; op_b_i = 0; op_c_i = 0;
        mem_ready_i = 0; ready_i = 1; issue_i = '1; commit_i = '1; kill_i = '0;
    endtask

    task automatic send(input logic [1:0] ins, input logic [3:0] id, input logic [4:0] rd,
                        input logic [31:0] base, input logic [11:0] off,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        id_valid_i = 1; id_instr_i = ins; id_id_i = id; id_rd_i = rd;
        id_base_i = base; id_offset_i = off; op_a_i = a; op_b_i = b; op_c_i = c;
        nedge();
        id_valid_i = 0; id_instr_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; idle_inputs();
        nedge();
        for (int d = 0; d < 2; d++) begin
            total++; if (wbv[d] !== 1'b0 || wbr[d] !== 32'd0 || mv[d] !== 1'b0 || ma[d] !== 32'd0) begin bad++; $display("FAIL reset_outputs d%0d wbv=%b wbr=%h mv=%b ma=%h required all 0", d, wbv[d], wbr[d], mv[d], ma[d]); end
            total++; if (rdy[d] !== 1'b1) begin bad++; $display("FAIL reset_ready d%0d got=%b exp=1", d, rdy[d]); end
        end
        rst_i = 0;
        nedge();
    endtask

    task automatic test_dotp16();
        idle_inputs();
        send(2'd3, 4'd2, 5'd9, 0, 0, 32'h0003FFFE, 32'h00020004, 32'd10);
        total++; if (wbv[0] !== 1'b1 || wbr[0] !== 32'd8) begin bad++; $display("FAIL dotp16 wbv=%b wbr=%h exp 1/00000008", wbv[0], wbr[0]); end
        total++; if (wbrd[0] !== 5'd9 || wbi[0] !== 2'd3 || wbid[0] !== 4'd2) begin bad++; $display("FAIL dotp16_tags rd=%0d instr=%0d id=%0d exp 9/3/2", wbrd[0], wbi[0], wbid[0]); end
        nedge(); nedge();
    endtask

    task automatic test_dotp8();
        idle_inputs();
        send(2'd3, 4'd1, 5'd4, 0, 0, 32'h01020304, 32'h01010101, 32'd0);
        for (int k = 0; k < 2; k++) begin
            total++; if (rdy[1] !== 1'b0 || wbv[1] !== 1'b0) begin bad++; $display("FAIL dotp8_busy k%0d rdy=%b wbv=%b exp 0/0", k, rdy[1], wbv[1]); end
            nedge();
        end
        total++; if (wbv[1] !== 1'b1 || wbr[1] !== 32'd10 || rdy[1] !== 1'b1) begin bad++; $display("FAIL dotp8_result wbv=%b wbr=%h rdy=%b exp 1/0000000a/1", wbv[1], wbr[1], rdy[1]); end
    endtask

    task automatic test_dotp_random();
        idle_inputs();
        for (int n = 0; n < 16; n++) begin
            logic [31:0] a = $urandom, b = $urandom, c = $urandom;
            logic [3:0] id = 4'($urandom_range(0, 15));
            logic [4:0] rd = 5'($urandom_range(0, 31));
            send(2'd3, id, rd, 0, 0, a, b, c);
            total++; if (wbv[0] !== 1'b1 || wbr[0] !== m_dotp(a, b, c, 16) || wbid[0] !== id || wbrd[0] !== rd) begin bad++; $display("FAIL dotp16_rand n%0d wbv=%b wbr=%h id=%0d rd=%0d exp 1/%h/%0d/%0d", n, wbv[0], wbr[0], wbid[0], wbrd[0], m_dotp(a, b, c, 16), id, rd); end
            nedge(); nedge();
            total++; if (wbv[1] !== 1'b1 || wbr[1] !== m_dotp(a, b, c, 8) || wbi[1] !== 2'd3 || wbid[1] !== id) begin bad++; $display("FAIL dotp8_rand n%0d wbv=%b wbr=%h instr=%0d id=%0d exp 1/%h/3/%0d", n, wbv[1], wbr[1], wbi[1], wbid[1], m_dotp(a, b, c, 8), id); end
        end
    endtask

    task automatic test_circ();
        logic [11:0] offs [2] = '{12'h000, 12'hFFC};
        logic [31:0] ea [2] = '{32'h100C, 32'h1008};
        logic [31:0] en [2] = '{32'h1000, 32'h100C};
        idle_inputs();
        for (int t = 0; t < 2; t++) begin
            send(2'd1, 4'd3, 5'd7, 32'h100C, offs[t], 0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                total++; if (mv[d] !== 1'b1 || ma[d] !== ea[t] || mwe[d] !== 1'b0 || mid[d] !== 4'd3) begin bad++; $display("FAIL circ_req t%0d d%0d mv=%b addr=%h we=%b id=%0d exp 1/%h/0/3", t, d, mv[d], ma[d], mwe[d], mid[d], ea[t]); end
            end
            mem_ready_i = 1;
            nedge();
            mem_ready_i = 0;
            for (int d = 0; d < 2; d++) begin
                total++; if (wbv[d] !== 1'b1 || wbr[d] !== en[t] || wbi[d] !== 2'd1 || wbrd[d] !== 5'd7) begin bad++; $display("FAIL circ_wb t%0d d%0d wbv=%b wbr=%h instr=%0d rd=%0d exp 1/%h/1/7", t, d, wbv[d], wbr[d], wbi[d], wbrd[d], en[t]); end
            end
            nedge();
        end
    endtask

    task automatic test_store_stall();
        logic [31:0] wd = $urandom;
        idle_inputs();
        send(2'd2, 4'd5, 5'd3, 32'h1004, 12'h000, 0, wd, 0);
        for (int k = 0; k < 3; k++) begin
            total++; if (mv[0] !== 1'b1 || ma[0] !== 32'h1004 || mwd[0] !== wd || mwe[0] !== 1'b1 || wbv[0] !== 1'b0) begin bad++; $display("FAIL sw_stall k%0d mv=%b addr=%h wdata=%h we=%b wbv=%b exp 1/00001004/%h/1/0", k, mv[0], ma[0], mwd[0], mwe[0], wbv[0], wd); end
            if (k < 2) nedge();
        end
        mem_ready_i = 1;
        nedge();
        mem_ready_i = 0;
        total++; if (wbv[0] !== 1'b1 || wbr[0] !== 32'h1008 || wbi[0] !== 2'd2) begin bad++; $display("FAIL sw_wb wbv=%b wbr=%h instr=%0d exp 1/00001008/2", wbv[0], wbr[0], wbi[0]); end
        nedge();
        total++; if (wbv[0] !== 1'b0 || mv[0] !== 1'b0) begin bad++; $display("FAIL sw_single wbv=%b mv=%b exp 0/0", wbv[0], mv[0]); end
    endtask

    task automatic test_kill();
        idle_inputs();
        mem_ready_i = 1;
        commit_i[7] = 0;
        send(2'd1, 4'd7, 5'd1, 32'h1000, 12'h000, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            total++; if (mv[0] !== 1'b0 || rdy[0] !== 1'b0) begin bad++; $display("FAIL kill_wait k%0d mv=%b rdy=%b exp 0/0", k, mv[0], rdy[0]); end
            if (k == 0) nedge();
        end
        kill_i[7] = 1;
        total++; if (mv[0] !== 1'b0) begin bad++; $display("FAIL kill_mv got=%b exp=0", mv[0]); end
        nedge();
        total++; if (rdy[0] !== 1'b1 || wbv[0] !== 1'b0 || mv[0] !== 1'b0) begin bad++; $display("FAIL kill_abort rdy=%b wbv=%b mv=%b exp 1/0/0", rdy[0], wbv[0], mv[0]); end
        idle_inputs();
        nedge();
        total++; if (wbv[0] !== 1'b0 || wbv[1] !== 1'b0) begin bad++; $display("FAIL kill_nowb wbv=%b exp 00", wbv); end
    endtask

    task automatic test_mem_random();
        idle_inputs();
        for (int n = 0; n < 12; n++) begin
            logic [1:0] ins = 2'($urandom_range(1, 2));
            logic [3:0] id = 4'($urandom_range(0, 15));
            logic [31:0] base = 32'h0FF0 + 32'(4 * $urandom_range(0, 12));
            logic [11:0] off = 12'(4 * $urandom_range(0, 4) - 8);
            logic [31:0] wd = $urandom;
            int stall = $urandom_range(0, 3);
            logic [31:0] ea = m_addr(base, off);
            send(ins, id, 5'(n), base, off, 0, wd, 0);
            for (int k = 0; k < stall; k++) begin
                for (int d = 0; d < 2; d++) begin
                    total++; if (mv[d] !== 1'b1 || ma[d] !== ea || mwe[d] !== (ins == 2'd2) || (ins == 2'd2 && mwd[d] !== wd)) begin bad++; $display("FAIL mem_rand_req n%0d d%0d mv=%b addr=%h we=%b wdata=%h exp addr=%h wdata=%h", n, d, mv[d], ma[d], mwe[d], mwd[d], ea, wd); end
                end
                nedge();
            end
            mem_ready_i = 1;
            nedge();
            mem_ready_i = 0;
            for (int d = 0; d < 2; d++) begin
                total++; if (wbv[d] !== 1'b1 || wbr[d] !== m_next(ea) || wbid[d] !== id || wbi[d] !== ins) begin bad++; $display("FAIL mem_rand_wb n%0d d%0d wbv=%b wbr=%h id=%0d instr=%0d exp 1/%h/%0d/%0d", n, d, wbv[d], wbr[d], wbid[d], wbi[d], m_next(ea), id, ins); end
            end
        end
        nedge();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = $urandom, b1 = $urandom, c1 = $urandom;
        logic [31:0] a2 = $urandom, b2 = $urandom, c2 = $urandom;
        idle_inputs();
        ready_i = 0;
        send(2'd3, 4'd1, 5'd1, 0, 0, a1, b1, c1);
        nedge();
        total++; if (wbv[0] !== 1'b1 || rdy[0] !== 1'b0 || wbr[0] !== m_dotp(a1, b1, c1, 16)) begin bad++; $display("FAIL b2b_hold wbv=%b rdy=%b wbr=%h exp 1/0/%h", wbv[0], rdy[0], wbr[0], m_dotp(a1, b1, c1, 16)); end
        ready_i = 1;
        send(2'd3, 4'd2, 5'd2, 0, 0, a2, b2, c2);
        total++; if (wbv[0] !== 1'b1 || wbr[0] !== m_dotp(a2, b2, c2, 16) || wbid[0] !== 4'd2) begin bad++; $display("FAIL b2b_next wbv=%b wbr=%h id=%0d exp 1/%h/2", wbv[0], wbr[0], wbid[0], m_dotp(a2, b2, c2, 16)); end
        nedge();
        total++; if (wbv[0] !== 1'b0) begin bad++; $display("FAIL b2b_drain wbv=%b exp=0", wbv[0]); end
        clear_i = 1;
        nedge();
        clear_i = 0;
    endtask

    task automatic test_clear_reset();
        idle_inputs();
        send(2'd3, 4'd4, 5'd4, 0, 0, $urandom, $urandom, $urandom);
        total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL clr_busy rdy=%b exp=0", rdy[1]); end
        clear_i = 1;
        nedge();
        clear_i = 0;
        for (int d = 0; d < 2; d++) begin
            total++; if (wbv[d] !== 1'b0 || wbr[d] !== 32'd0 || mv[d] !== 1'b0 || rdy[d] !== 1'b1) begin bad++; $display("FAIL clear d%0d wbv=%b wbr=%h mv=%b rdy=%b exp 0/0/0/1", d, wbv[d], wbr[d], mv[d], rdy[d]); end
        end
        nedge(); nedge();
        total++; if (wbv[1] !== 1'b0) begin bad++; $display("FAIL clear_nowb wbv=%b exp=0", wbv[1]); end
        send(2'd1, 4'd6, 5'd6, 32'h1000, 12'h000, 0, 0, 0);
        total++; if (mv[0] !== 1'b1) begin bad++; $display("FAIL rst_pre mv=%b exp=1", mv[0]); end
        rst_i = 1;
        nedge();
        for (int d = 0; d < 2; d++) begin
            total++; if (mv[d] !== 1'b0 || ma[d] !== 32'd0 || wbv[d] !== 1'b0 || wbr[d] !== 32'd0 || rdy[d] !== 1'b1) begin bad++; $display("FAIL rst_mem d%0d mv=%b addr=%h wbv=%b wbr=%h rdy=%b exp 0/0/0/0/1", d, mv[d], ma[d], wbv[d], wbr[d], rdy[d]); end
        end
        rst_i = 0;
        nedge();
        total++; if (mv[0] !== 1'b0 || wbv[0] !== 1'b0) begin bad++; $display("FAIL rst_after mv=%b wbv=%b exp 0/0", mv[0], wbv[0]); end
    endtask

    initial begin
        rst_i = 1;
        buf_start_i = 32'h1000;
        buf_end_i = 32'h1010;
        idle_inputs();
        test_reset();
        test_dotp16();
        test_dotp8();
        test_dotp_random();
        test_circ();
        test_store_stall();
        test_kill();
        test_mem_random();
        test_back_to_back();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
